bridge_rshift_sched: RTL and testbench

Sequencing controller in front of the bridge/right-shift pipeline of the self-attention head. Accepts a valid/ready stream of input-matrix words and packs consecutive even/odd word pairs into single dual-port writes of the input BRAM. Once the matrix is loaded, it pulses the pipeline start and counts output beats to completion, with a watchdog timeout. It replaces the free-running "load then wait N cycles" sequencing with a deterministic, handshaked schedule.

---
 rtl/bridge_rshift_sched.sv | 210 +++++++++++++++++++++
 tb/tb_bridge_rshift_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_rshift_sched.sv
// Sequencing controller for the bridge/right-shift pipeline input stage.
// Packs even/odd pairs from a valid/ready word stream into dual-port BRAM
// writes, pulses the pipeline start once the matrix is loaded, and counts
// output beats to completion under a watchdog.
//
// Handshake: a word transfers on any rising clk edge where s_valid and
// s_ready are both high; s_ready is a registered output, so the producer
// may hold s_valid high or deassert it at will without extra state here.
module bridge_rshift_sched #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 6,
    parameter int NUM_ELEMENTS   = 48,
    parameter int NUM_OUT_BEATS  = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  bram_ena,
    output logic                  bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [DATA_WIDTH-1:0] bram_dina,
    output logic                  bram_enb,
    output logic                  bram_web,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    output logic [DATA_WIDTH-1:0] bram_dinb,
    output logic                  pipe_start,
    input  logic                  pipe_out_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [15:0]           out_beat_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]         TMO_LIMIT  = TW'(TIMEOUT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(NUM_ELEMENTS - 1);
    localparam logic [15:0]           BEAT_LIMIT = 16'(NUM_OUT_BEATS);
    localparam bit                    ODD_LOAD   = (NUM_ELEMENTS % 2) == 1;

    // The whole matrix must fit the input BRAM address space.
    if (NUM_ELEMENTS < 1 || NUM_ELEMENTS > (1 << ADDR_WIDTH)) begin : g_cfg_check
        $error("bridge_rshift_sched: NUM_ELEMENTS must be in 1..2**ADDR_WIDTH");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   word_idx, word_n;
    logic [DATA_WIDTH-1:0]   pair_q, pair_n;
    logic [TW-1:0]           tmo_cnt, tmo_n;

    logic                    s_ready_n;
    logic                    ena_n, wea_n, enb_n, web_n;
    logic [ADDR_WIDTH-1:0]   addra_n, addrb_n;
    logic [DATA_WIDTH-1:0]   dina_n, dinb_n;
    logic                    pipe_start_n, busy_n, done_n, terr_n;
    logic [15:0]             cnt_n;
    logic                    accept;
    logic                    beat_hit;

    assign accept   = s_valid & s_ready;
    assign beat_hit = pipe_out_valid && (out_beat_cnt < BEAT_LIMIT);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n      = state;
        word_n       = word_idx;
        pair_n       = pair_q;
        tmo_n        = tmo_cnt;
        ena_n        = 1'b0;
        wea_n        = 1'b0;
        enb_n        = 1'b0;
        web_n        = 1'b0;
        addra_n      = bram_addra;
        dina_n       = bram_dina;
        addrb_n      = bram_addrb;
        dinb_n       = bram_dinb;
        pipe_start_n = 1'b0;
        busy_n       = busy;
        done_n       = 1'b0;
        terr_n       = timeout_err;
        cnt_n        = out_beat_cnt;

        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    state_n = S_LOAD;
                    busy_n  = 1'b1;
                    terr_n  = 1'b0;
                    cnt_n   = '0;
                    word_n  = '0;
                    tmo_n   = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (!word_idx[0]) begin
                        // Even word waits for its odd partner.
                        pair_n = s_data;
                    end else begin
                        ena_n   = 1'b1;
                        wea_n   = 1'b1;
                        addra_n = word_idx - ADDR_WIDTH'(1);
                        dina_n  = pair_q;
                        enb_n   = 1'b1;
                        web_n   = 1'b1;
                        addrb_n = word_idx;
                        dinb_n  = s_data;
                    end
                    if (word_idx == LAST_IDX) begin
                        state_n = ODD_LOAD ? S_FLUSH : S_START;
                    end else begin
                        word_n = word_idx + ADDR_WIDTH'(1);
                    end
                end
            end
            S_FLUSH: begin
                // Unpaired tail word goes out on port A alone.
                ena_n   = 1'b1;
                wea_n   = 1'b1;
                addra_n = LAST_IDX;
                dina_n  = pair_q;
                state_n = S_START;
            end
            S_START: begin
                pipe_start_n = 1'b1;
                tmo_n        = '0;
                state_n      = S_RUN;
            end
            S_RUN: begin
                tmo_n = tmo_cnt + TW'(1);
                if (beat_hit) begin
                    cnt_n = out_beat_cnt + 16'd1;
                end
                // Completion is tested first so a same-cycle tie is not an error.
                if (cnt_n == BEAT_LIMIT) begin
                    state_n = S_DONE;
                end else if (tmo_n == TMO_LIMIT) begin
                    terr_n  = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        s_ready_n = (state_n == S_LOAD);
    end

    // State, counters and registered outputs; synchronous reset clears all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            word_idx     <= '0;
            pair_q       <= '0;
            tmo_cnt      <= '0;
            s_ready      <= 1'b0;
            bram_ena     <= 1'b0;
            bram_wea     <= 1'b0;
            bram_addra   <= '0;
            bram_dina    <= '0;
            bram_enb     <= 1'b0;
            bram_web     <= 1'b0;
            bram_addrb   <= '0;
            bram_dinb    <= '0;
            pipe_start   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            out_beat_cnt <= '0;
        end else begin
            state        <= state_n;
            word_idx     <= word_n;
            pair_q       <= pair_n;
            tmo_cnt      <= tmo_n;
            s_ready      <= s_ready_n;
            bram_ena     <= ena_n;
            bram_wea     <= wea_n;
            bram_addra   <= addra_n;
            bram_dina    <= dina_n;
            bram_enb     <= enb_n;
            bram_web     <= web_n;
            bram_addrb   <= addrb_n;
            bram_dinb    <= dinb_n;
            pipe_start   <= pipe_start_n;
            busy         <= busy_n;
            done         <= done_n;
            timeout_err  <= terr_n;
            out_beat_cnt <= cnt_n;
        end
    end

endmodule

// File: tb/tb_bridge_rshift_sched.sv
// Directed bench for bridge_rshift_sched: an even-length instance (48 words)
// and an odd-length instance (5 words, short watchdog) share clock and reset.
module tb_bridge_rshift_sched;

    localparam int DW = 64;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst;

    logic          cfg_start      [2];
    logic          s_valid        [2];
    logic [DW-1:0] s_data         [2];
    logic          s_ready        [2];
    logic          bram_ena       [2];
    logic          bram_wea       [2];
    logic [AW-1:0] bram_addra     [2];
    logic [DW-1:0] bram_dina      [2];
    logic          bram_enb       [2];
    logic          bram_web       [2];
    logic [AW-1:0] bram_addrb     [2];
    logic [DW-1:0] bram_dinb      [2];
    logic          pipe_start     [2];
    logic          pipe_out_valid [2];
    logic          busy           [2];
    logic          done           [2];
    logic          timeout_err    [2];
    logic [15:0]   out_beat_cnt   [2];

    logic          clr_req        [2];
    logic [DW-1:0] mem            [2][64];
    int            wr_total       [2];
    int            wr_a_only      [2];
    int            wr_b_only      [2];
    int            ps_cnt         [2];
    int            done_cnt       [2];

    int checks = 0;
    int errors = 0;

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    bridge_rshift_sched #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ELEMENTS(48),
        .NUM_OUT_BEATS(16), .TIMEOUT_CYCLES(4096)
    ) dut_even (
        .clk(clk), .rst(rst), .cfg_start(cfg_start[0]),
        .s_valid(s_valid[0]), .s_data(s_data[0]), .s_ready(s_ready[0]),
        .bram_ena(bram_ena[0]), .bram_wea(bram_wea[0]),
        .bram_addra(bram_addra[0]), .bram_dina(bram_dina[0]),
        .bram_enb(bram_enb[0]), .bram_web(bram_web[0]),
        .bram_addrb(bram_addrb[0]), .bram_dinb(bram_dinb[0]),
        .pipe_start(pipe_start[0]), .pipe_out_valid(pipe_out_valid[0]),
        .busy(busy[0]), .done(done[0]), .timeout_err(timeout_err[0]),
        .out_beat_cnt(out_beat_cnt[0])
    );

    bridge_rshift_sched #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ELEMENTS(5),
        .NUM_OUT_BEATS(16), .TIMEOUT_CYCLES(64)
    ) dut_odd (
        .clk(clk), .rst(rst), .cfg_start(cfg_start[1]),
        .s_valid(s_valid[1]), .s_data(s_data[1]), .s_ready(s_ready[1]),
        .bram_ena(bram_ena[1]), .bram_wea(bram_wea[1]),
        .bram_addra(bram_addra[1]), .bram_dina(bram_dina[1]),
        .bram_enb(bram_enb[1]), .bram_web(bram_web[1]),
        .bram_addrb(bram_addrb[1]), .bram_dinb(bram_dinb[1]),
        .pipe_start(pipe_start[1]), .pipe_out_valid(pipe_out_valid[1]),
        .busy(busy[1]), .done(done[1]), .timeout_err(timeout_err[1]),
        .out_beat_cnt(out_beat_cnt[1])
    );

    // BRAM image and event counters, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (clr_req[i]) begin
                for (int a = 0; a < 64; a++) mem[i][a] = '0;
                wr_total[i]  = 0;
                wr_a_only[i] = 0;
                wr_b_only[i] = 0;
                ps_cnt[i]    = 0;
                done_cnt[i]  = 0;
            end else begin
                if (bram_ena[i] && bram_wea[i]) mem[i][bram_addra[i]] = bram_dina[i];
                if (bram_enb[i] && bram_web[i]) mem[i][bram_addrb[i]] = bram_dinb[i];
                if (bram_ena[i] || bram_enb[i]) wr_total[i]++;
                if (bram_ena[i] && !bram_enb[i]) wr_a_only[i]++;
                if (bram_enb[i] && !bram_ena[i]) wr_b_only[i]++;
                if (pipe_start[i]) ps_cnt[i]++;
                if (done[i]) done_cnt[i]++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon(input int i);
        clr_req[i] = 1'b1;
        tick();
        clr_req[i] = 1'b0;
    endtask

    task automatic start_job(input int i);
        cfg_start[i] = 1'b1;
        tick();
        cfg_start[i] = 1'b0;
    endtask

    // Offers words first..last (data = index); gap idle cycles after each.
    task automatic feed(input int i, input int first, input int last, input int gap);
        for (int k = first; k <= last; k++) begin
            int guard;
            guard = 0;
            s_valid[i] = 1'b1;
            s_data[i]  = DW'(k);
            while (!s_ready[i] && guard < 50) begin
                tick();
                guard++;
            end
            chk("feed_ready", s_ready[i], 1'b1);
            tick();
            s_valid[i] = 1'b0;
            repeat (gap) tick();
        end
        s_valid[i] = 1'b0;
    endtask

    task automatic chk_image(input int i, input int n, input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) if (mem[i][k] !== DW'(k)) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic chk_quiet(input int i, input string tag);
        chk({tag, "_s_ready"}, s_ready[i], 1'b0);
        chk({tag, "_ena"}, bram_ena[i], 1'b0);
        chk({tag, "_enb"}, bram_enb[i], 1'b0);
        chk({tag, "_addra"}, bram_addra[i], 0);
        chk({tag, "_dina"}, bram_dina[i], 0);
        chk({tag, "_pipe_start"}, pipe_start[i], 1'b0);
        chk({tag, "_busy"}, busy[i], 1'b0);
        chk({tag, "_done"}, done[i], 1'b0);
        chk({tag, "_terr"}, timeout_err[i], 1'b0);
        chk({tag, "_cnt"}, out_beat_cnt[i], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cfg_start[i] = 1'b0; s_valid[i] = 1'b0; s_data[i] = '0;
            pipe_out_valid[i] = 1'b0; clr_req[i] = 1'b0;
        end
        repeat (3) tick();
        chk_quiet(0, "rst_even");
        chk_quiet(1, "rst_odd");
        rst = 1'b0;
        tick();

        // ---- Even load, continuous, 3 beats injected during LOAD ----
        clear_mon(0);
        start_job(0);
        chk("even_ready_c1", s_ready[0], 1'b1);
        chk("even_busy_c1", busy[0], 1'b1);
        pipe_out_valid[0] = 1'b1;
        feed(0, 0, 2, 0);
        pipe_out_valid[0] = 1'b0;
        feed(0, 3, 47, 0);
        chk("even_last_ena", bram_ena[0], 1'b1);
        chk("even_last_enb", bram_enb[0], 1'b1);
        chk("even_last_addra", bram_addra[0], 46);
        chk("even_last_addrb", bram_addrb[0], 47);
        chk("even_last_dina", bram_dina[0], 46);
        chk("even_last_dinb", bram_dinb[0], 47);
        chk("even_ready_drop", s_ready[0], 1'b0);
        chk("even_no_early_start", pipe_start[0], 1'b0);
        chk("even_load_beats_ignored", out_beat_cnt[0], 0);
        tick();
        chk("even_pipe_start", pipe_start[0], 1'b1);
        chk("even_ena_after", bram_ena[0], 1'b0);
        chk("even_wr_total", wr_total[0], 24);
        chk("even_wr_a_only", wr_a_only[0], 0);
        chk("even_wr_b_only", wr_b_only[0], 0);
        chk_image(0, 48, "even_image");
        pipe_out_valid[0] = 1'b1;
        repeat (16) tick();
        pipe_out_valid[0] = 1'b0;
        chk("even_cnt16", out_beat_cnt[0], 16);
        chk("even_done_not_yet", done[0], 1'b0);
        chk("even_ps_once", ps_cnt[0], 1);
        cfg_start[0] = 1'b1;  // arrives while in DONE: must be ignored
        tick();
        cfg_start[0] = 1'b0;
        chk("even_done", done[0], 1'b1);
        chk("even_busy_fall", busy[0], 1'b0);
        chk("even_terr", timeout_err[0], 1'b0);
        tick();
        chk("even_done_1cyc", done[0], 1'b0);
        chk("even_done_exit_start_ignored", busy[0], 1'b0);
        chk("even_done_exit_no_load", s_ready[0], 1'b0);
        chk("even_cnt_hold", out_beat_cnt[0], 16);

        // ---- Even load with backpressure gaps (valid 1,0,0,1,...) ----
        clear_mon(0);
        start_job(0);
        chk("gap_cnt_cleared", out_beat_cnt[0], 0);
        feed(0, 0, 0, 2);
        chk("gap_no_half_write", wr_total[0], 0);
        chk("gap_no_half_ena", bram_ena[0], 1'b0);
        feed(0, 1, 1, 0);
        chk("gap_pair_ena", bram_ena[0], 1'b1);
        chk("gap_pair_enb", bram_enb[0], 1'b1);
        chk("gap_pair_addra", bram_addra[0], 0);
        chk("gap_pair_addrb", bram_addrb[0], 1);
        feed(0, 2, 47, 2);
        chk("gap_wr_total", wr_total[0], 24);
        chk("gap_ps_once", ps_cnt[0], 1);
        chk_image(0, 48, "gap_image");
        pipe_out_valid[0] = 1'b1;
        repeat (16) tick();
        pipe_out_valid[0] = 1'b0;
        tick();
        chk("gap_done", done[0], 1'b1);
        chk("gap_cnt", out_beat_cnt[0], 16);

        // ---- Odd tail (5 words) then watchdog timeout with 10 beats ----
        clear_mon(1);
        start_job(1);
        feed(1, 0, 1, 0);
        chk("odd_p0_addra", bram_addra[1], 0);
        chk("odd_p0_addrb", bram_addrb[1], 1);
        chk("odd_p0_enb", bram_enb[1], 1'b1);
        feed(1, 2, 3, 0);
        chk("odd_p1_addra", bram_addra[1], 2);
        chk("odd_p1_dinb", bram_dinb[1], 3);
        feed(1, 4, 4, 0);
        chk("odd_hold_no_write", bram_ena[1], 1'b0);
        chk("odd_ready_drop", s_ready[1], 1'b0);
        tick();
        chk("odd_tail_ena", bram_ena[1], 1'b1);
        chk("odd_tail_wea", bram_wea[1], 1'b1);
        chk("odd_tail_addra", bram_addra[1], 4);
        chk("odd_tail_dina", bram_dina[1], 4);
        chk("odd_tail_enb", bram_enb[1], 1'b0);
        chk("odd_tail_web", bram_web[1], 1'b0);
        chk("odd_tail_no_start", pipe_start[1], 1'b0);
        tick();
        chk("odd_pipe_start", pipe_start[1], 1'b1);
        chk("odd_wr_total", wr_total[1], 3);
        chk("odd_wr_a_only", wr_a_only[1], 1);
        chk_image(1, 5, "odd_image");
        pipe_out_valid[1] = 1'b1;
        repeat (10) tick();
        pipe_out_valid[1] = 1'b0;
        repeat (53) tick();
        chk("tmo_not_yet", timeout_err[1], 1'b0);
        chk("tmo_busy", busy[1], 1'b1);
        tick();
        chk("tmo_err", timeout_err[1], 1'b1);
        chk("tmo_cnt10", out_beat_cnt[1], 10);
        chk("tmo_done_not_yet", done[1], 1'b0);
        tick();
        chk("tmo_done", done[1], 1'b1);
        chk("tmo_busy_fall", busy[1], 1'b0);
        chk("tmo_err_sticky", timeout_err[1], 1'b1);
        tick();
        start_job(1);
        chk("tmo_err_cleared", timeout_err[1], 1'b0);
        chk("tmo_cnt_cleared", out_beat_cnt[1], 0);

        // ---- Final beat lands on the timeout cycle: completion wins ----
        feed(1, 0, 4, 0);
        tick();
        tick();
        chk("tie_pipe_start", pipe_start[1], 1'b1);
        pipe_out_valid[1] = 1'b1;
        repeat (15) tick();
        pipe_out_valid[1] = 1'b0;
        repeat (48) tick();
        chk("tie_cnt15", out_beat_cnt[1], 15);
        pipe_out_valid[1] = 1'b1;
        tick();
        pipe_out_valid[1] = 1'b0;
        chk("tie_cnt16", out_beat_cnt[1], 16);
        chk("tie_no_err", timeout_err[1], 1'b0);
        tick();
        chk("tie_done", done[1], 1'b1);
        chk("tie_no_err_done", timeout_err[1], 1'b0);

        // ---- Reset after 7 accepted words ----
        clear_mon(0);
        start_job(0);
        feed(0, 0, 6, 0);
        rst = 1'b1;
        s_valid[0] = 1'b1;
        s_data[0]  = 64'h99;
        tick();
        chk_quiet(0, "midrst");
        tick();
        rst = 1'b0;
        repeat (3) tick();
        s_valid[0] = 1'b0;
        chk("midrst_wr_total", wr_total[0], 3);
        chk("midrst_no_ready", s_ready[0], 1'b0);

        // ---- Fresh job; cfg_start pulses while busy are ignored ----
        clear_mon(0);
        start_job(0);
        feed(0, 0, 9, 0);
        cfg_start[0] = 1'b1;
        feed(0, 10, 10, 0);
        cfg_start[0] = 1'b0;
        chk("busy_start_ignored_busy", busy[0], 1'b1);
        feed(0, 11, 47, 0);
        chk("fresh_last_addrb", bram_addrb[0], 47);
        tick();
        chk("fresh_pipe_start", pipe_start[0], 1'b1);
        pipe_out_valid[0] = 1'b1;
        repeat (5) tick();
        cfg_start[0] = 1'b1;
        tick();
        cfg_start[0] = 1'b0;
        chk("run_start_ignored_cnt", out_beat_cnt[0], 6);
        chk("run_start_ignored_busy", busy[0], 1'b1);
        repeat (10) tick();
        pipe_out_valid[0] = 1'b0;
        chk("fresh_cnt16", out_beat_cnt[0], 16);
        tick();
        chk("fresh_done", done[0], 1'b1);
        chk("fresh_terr", timeout_err[0], 1'b0);
        chk("fresh_wr_total", wr_total[0], 24);
        chk("fresh_ps_once", ps_cnt[0], 1);
        chk_image(0, 48, "fresh_image");
        tick();
        chk("fresh_done_count", done_cnt[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
